// File: rtl/bnn_conv2d_seq.sv
// Sequential binary 3x3 'same' convolution with per-channel popcount threshold.
// One output pixel per clock, iterating channel -> row -> column; maps held until next start.
//
// Packing: weights[oc*9 + kr*3 + kc], thresh[oc*4 +: 4],
// img_out[oc*IMG_SIZE^2 + row*IMG_SIZE + col].
module bnn_conv2d_seq #(
  parameter int IMG_SIZE = 28,
  parameter int OC       = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [IMG_SIZE*IMG_SIZE-1:0]     img_in,
  input  logic [9*OC-1:0]                  weights,
  input  logic [4*OC-1:0]                  thresh,
  output logic                             busy,
  output logic                             done,
  output logic                             out_valid,
  output logic [OC*IMG_SIZE*IMG_SIZE-1:0]  img_out
);

  localparam int N2    = IMG_SIZE * IMG_SIZE;
  localparam int NPIX  = OC * N2;
  localparam int POS_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int OC_W  = (OC > 1) ? $clog2(OC) : 1;
  localparam int IDX_W = (N2 > 1) ? $clog2(N2) : 1;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [N2-1:0]    img_q;
  logic [8:0]       w_q  [OC];
  logic [3:0]       th_q [OC];

  logic [OC_W-1:0]  oc_q;
  logic [POS_W-1:0] row_q, col_q;
  logic [PIX_W-1:0] pix_q;

  logic             col_wrap, row_wrap, last_pix;
  logic             accept;
  logic [8:0]       win, match;
  logic [3:0]       pc;
  logic             out_bit;

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    col_wrap = (col_q == POS_W'(IMG_SIZE - 1));
    row_wrap = (row_q == POS_W'(IMG_SIZE - 1));
    last_pix = col_wrap && row_wrap && (oc_q == OC_W'(OC - 1));
  end

  // ---------------------------------------------------------------- FSM
  // NOTE: state and all other registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_pix) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ operand capture
  // NOTE: the captured frame operands carry no reset: they are always rewritten
  // by an accepted start before being read, so a reset term would only add logic.
  always_ff @(posedge clk) begin
    if (accept) begin
      img_q <= img_in;
      for (int i = 0; i < OC; i++) begin
        w_q[i]  <= weights[i*9 +: 9];
        th_q[i] <= thresh[i*4 +: 4];
      end
    end
  end

  // -------------------------------------------------- window and popcount
  always_comb begin
    int r;
    int c;
    logic [IDX_W-1:0] bidx;
    win   = '0;
    bidx  = '0;
    r     = 0;
    c     = 0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        r = int'(row_q) + kr - 1;
        c = int'(col_q) + kc - 1;
        // Zero padding: taps falling outside the image read as 0.
        if (r >= 0 && r < IMG_SIZE && c >= 0 && c < IMG_SIZE) begin
          bidx            = IDX_W'(r * IMG_SIZE + c);
          win[kr*3 + kc]  = img_q[bidx];
        end
      end
    end
    match = ~(win ^ w_q[oc_q]);
    pc    = '0;
    for (int i = 0; i < 9; i++) pc = pc + 4'(match[i]);
    out_bit = (pc >= th_q[oc_q]);
  end

  // ------------------------------------------- counters and output maps
  always_ff @(posedge clk) begin
    if (rst) begin
      img_out   <= '0;
      out_valid <= 1'b0;
      oc_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pix_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b0;
      oc_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pix_q     <= '0;
    end else if (state_q == S_RUN) begin
      img_out[pix_q] <= out_bit;
      pix_q          <= pix_q + PIX_W'(1);
      if (col_wrap) begin
        col_q <= '0;
        if (row_wrap) begin
          row_q <= '0;
          oc_q  <= oc_q + OC_W'(1);
        end else begin
          row_q <= row_q + POS_W'(1);
        end
      end else begin
        col_q <= col_q + POS_W'(1);
      end
      // Raised together with the move to DONE so it is already high in the done cycle.
      if (last_pix) out_valid <= 1'b1;
    end
  end

endmodule
